// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC operation encoding and instruction length.
package pc_pkg;
  localparam int ILEN_BYTES = 4;
  typedef enum logic [1:0] {OP_SEQ = 2'd0, OP_JAL = 2'd1, OP_JALR = 2'd2, OP_BRANCH = 2'd3} op_e;
endpackage

// File: rtl/pc_skid_fifo.sv
// pc_skid_fifo: in-order valid/ready buffer with flush; data holds last shown value when empty.
module pc_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q, last_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy_q, full, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full      = cnt_q == CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign in_ready  = rdy_q && (!full || out_ready);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_q] : last_q;
  always_comb begin
    rd_d   = flush ? '0 : pop ? nxt(rd_q) : rd_q;
    wr_d   = flush ? '0 : push ? nxt(wr_q) : wr_q;
    cnt_d  = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    last_d = out_valid ? mem_q[rd_q] : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      rdy_q  <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end
endmodule

// File: rtl/pc_target_gen.sv
// pc_target_gen: next-PC/link/redirect generator with skid output buffer; PC_TARGET_RVC_EN adds compressed-instruction support.
module pc_target_gen
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [1:0]      in_op,
  input  logic            in_taken,
`ifdef PC_TARGET_RVC_EN
  input  logic            in_is_c,
`endif
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_redirect,
  output logic            out_misalign
);
  op_e op;
  logic [XLEN-1:0] seq_inc, pc_seq, pc_rel, rs1_rel, target;
  logic redirect, misalign;
  always_comb begin
    op = op_e'(in_op);
`ifdef PC_TARGET_RVC_EN
    seq_inc = in_is_c ? XLEN'(2) : XLEN'(ILEN_BYTES);
`else
    seq_inc = XLEN'(ILEN_BYTES);
`endif
    pc_seq   = in_pc + seq_inc;
    pc_rel   = in_pc + in_imm;
    rs1_rel  = (in_rs1 + in_imm) & ~XLEN'(1);
    redirect = op == OP_JAL || op == OP_JALR || (op == OP_BRANCH && in_taken);
    target   = op == OP_JALR ? rs1_rel : redirect ? pc_rel : pc_seq;
`ifdef PC_TARGET_RVC_EN
    misalign = target[0];
`else
    misalign = |target[1:0];
`endif
  end
  pc_skid_fifo #(.WIDTH(2 * XLEN + 2), .DEPTH(SKID_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({target, pc_seq, redirect, misalign}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_target, out_link, out_redirect, out_misalign})
  );
endmodule

// File: tb/tb_pc_target_gen.sv
// tb_pc_target_gen: directed checks of target math, buffering, flush and reset (default build).
module tb_pc_target_gen;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_taken = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0;
  logic [1:0] in_op = '0;
  logic in_ready, out_valid, out_redirect, out_misalign;
  logic [31:0] out_target, out_link;
  logic [66:0] obs, exp_v;
  int tests = 0, fails = 0;
  assign obs = {out_valid, out_target, out_link, out_redirect, out_misalign};
  always #5 clk = ~clk;
  pc_target_gen #(.XLEN(32), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_op(in_op), .in_taken(in_taken),
`ifdef PC_TARGET_RVC_EN
    .in_is_c(1'b0),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_target(out_target), .out_link(out_link),
    .out_redirect(out_redirect), .out_misalign(out_misalign)
  );
  task automatic drive(input logic [1:0] op, input logic [31:0] pc, imm, rs1, input logic tk);
    in_op = op; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_taken = tk; in_valid = 1'b1;
  endtask
  task automatic test_reset;
    #2;
    tests++;
    if ({obs, in_ready} !== 68'h0) begin
      fails++; $display("FAIL reset_outputs: got %h exp %h", {obs, in_ready}, 68'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_rise: got %b exp 1", in_ready);
    end
  endtask
  task automatic test_jal;
    drive(2'd1, 32'h100, 32'h20, 32'h0, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    exp_v = {1'b1, 32'h120, 32'h104, 1'b1, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL jal: got %h exp %h", obs, exp_v);
    end
    drive(2'd1, 32'h100, 32'h2, 32'h0, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    exp_v = {1'b1, 32'h102, 32'h104, 1'b1, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL jal_misalign: got %h exp %h", obs, exp_v);
    end
  endtask
  task automatic test_jalr;
    drive(2'd2, 32'h400, 32'h0, 32'h203, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    exp_v = {1'b1, 32'h202, 32'h404, 1'b1, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL jalr: got %h exp %h", obs, exp_v);
    end
  endtask
  task automatic test_branch;
    drive(2'd3, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b1);
    @(negedge clk) drive(2'd3, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0);
    exp_v = {1'b1, 32'h4, 32'h0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL branch_taken_wrap: got %h exp %h", obs, exp_v);
    end
    @(negedge clk) in_valid = 1'b0;
    exp_v = {1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL branch_not_taken: got %h exp %h", obs, exp_v);
    end
  endtask
  task automatic test_seq_hold;
    drive(2'd0, 32'h1000, 32'h40, 32'h0, 1'b1);
    @(negedge clk) in_valid = 1'b0;
    exp_v = {1'b1, 32'h1004, 32'h1004, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL seq: got %h exp %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b0, 32'h1004, 32'h1004, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL empty_hold: got %h exp %h", obs, exp_v);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] order [3];
    order[0] = 32'h14; order[1] = 32'h24; order[2] = 32'h34;
    out_ready = 1'b0;
    drive(2'd0, 32'h10, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready_one: got %b exp 1", in_ready);
    end
    drive(2'd0, 32'h20, 32'h0, 32'h0, 1'b0);
    @(negedge clk) drive(2'd0, 32'h30, 32'h0, 32'h0, 1'b0);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full: got %b exp 0", in_ready);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, out_target, in_ready} !== {1'b1, 32'h14, 1'b0}) begin
      fails++; $display("FAIL bp_stable: got %h exp %h", {out_valid, out_target, in_ready}, {1'b1, 32'h14, 1'b0});
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_full_pop_ready: got %b exp 1", in_ready);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk) in_valid = 1'b0;
      tests++;
      if ({out_valid, out_target} !== {1'b1, order[i]}) begin
        fails++; $display("FAIL bp_order%0d: got %h exp %h", i, {out_valid, out_target}, {1'b1, order[i]});
      end
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_drained: got %b exp 0", out_valid);
    end
  endtask
  task automatic test_flush;
    out_ready = 1'b0;
    drive(2'd0, 32'h40, 32'h0, 32'h0, 1'b0);
    @(negedge clk) drive(2'd0, 32'h50, 32'h0, 32'h0, 1'b0);
    @(negedge clk) drive(2'd1, 32'h60, 32'h100, 32'h0, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready} !== 2'b11) begin
      fails++; $display("FAIL flush_setup: got %b exp 11", {out_valid, in_ready});
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_empty: got %b exp 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || out_target === 32'h160) begin
        fails++; $display("FAIL flush_drop%0d: got valid %b target %h exp valid 0", i, out_valid, out_target);
      end
    end
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(2'd1, 32'h200, 32'h10, 32'h0, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    tests++;
    if (obs !== {1'b1, 32'h210, 32'h204, 1'b1, 1'b0}) begin
      fails++; $display("FAIL midrst_pre: got %h exp %h", obs, {1'b1, 32'h210, 32'h204, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({obs, in_ready} !== 68'h0) begin
      fails++; $display("FAIL midrst_async: got %h exp %h", {obs, in_ready}, 68'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL midrst_release: got %b exp 01", {out_valid, in_ready});
    end
  endtask
  initial begin
    test_reset;
    test_jal;
    test_jalr;
    test_branch;
    test_seq_hold;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
